// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, default widths and the reservation-station entry layout.
package tomasulo_pkg;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W  = 3;
  localparam int DEF_FUNC_W = 4;

  localparam logic [DEF_FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [DEF_FUNC_W-1:0] FUNC_SUB = 4'b0001;
  localparam logic [DEF_FUNC_W-1:0] FUNC_MUL = 4'b0010;
  localparam logic [DEF_FUNC_W-1:0] FUNC_DIV = 4'b0011;
  localparam logic [DEF_FUNC_W-1:0] FUNC_LD  = 4'b0100;
  localparam logic [DEF_FUNC_W-1:0] FUNC_ST  = 4'b0101;
  localparam logic [DEF_FUNC_W-1:0] FUNC_BEQ = 4'b0110;
  localparam logic [DEF_FUNC_W-1:0] FUNC_BNE = 4'b0111;

  typedef struct packed {
    logic                           valid;
    logic [DEF_FUNC_W-1:0]          func;
    logic [DEF_TAG_W-1:0]           rob;
    logic                           rdy1;
    logic [DEF_DATA_W-1:0]          v1;
    logic                           rdy2;
    logic [DEF_DATA_W-1:0]          v2;
    logic [$clog2(DEF_DEPTH)-1:0]   age;
  } rs_entry_t;
endpackage

// File: rtl/rs_oldest_sel.sv
// Picks the oldest ready entry: one-hot grant to the candidate with the largest age.
module rs_oldest_sel #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 2
) (
  input  logic [DEPTH-1:0]            cand_i,
  input  logic [DEPTH-1:0][AGE_W-1:0] age_i,
  output logic [DEPTH-1:0]            grant_o,
  output logic                        any_valid_o
);
  // Equal ages (only reachable through saturation) resolve to the lower index.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = cand_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand_i[j]) begin
          if (age_i[j] > age_i[i] || (age_i[j] == age_i[i] && j < i)) grant_o[i] = 1'b0;
        end
      end
    end
  end

  assign any_valid_o = |cand_i;
endmodule

// File: rtl/rs_station_param.sv
// Reservation station: issue into a free slot, CDB wakeup, oldest-ready dispatch, flush.
module rs_station_param
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int FUNC_W = DEF_FUNC_W
) (
  input  logic                       clk2,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [FUNC_W-1:0]          iss_func,
  input  logic [TAG_W-1:0]           iss_rob,
  input  logic                       iss_s1_rdy,
  input  logic [DATA_W-1:0]          iss_s1,
  input  logic                       iss_s2_rdy,
  input  logic [DATA_W-1:0]          iss_s2,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [FUNC_W-1:0]          disp_func,
  output logic [TAG_W-1:0]           disp_rob,
  output logic [DATA_W-1:0]          disp_op1,
  output logic [DATA_W-1:0]          disp_op2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AGE_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [DEPTH-1:0]             valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [DEPTH-1:0][AGE_W-1:0]  age_q, age_d;
  logic [DEPTH-1:0][FUNC_W-1:0] func_q, func_d;
  logic [DEPTH-1:0][TAG_W-1:0]  rob_q, rob_d;
  logic [DEPTH-1:0][DATA_W-1:0] v1_q, v1_d, v2_q, v2_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [AGE_W-1:0]             free_idx;
  logic [DEPTH-1:0]             grant;
  logic                         iss_fire, disp_fire;
  logic [DATA_W:0]              cap1, cap2;

  // Operand capture at issue, including the same-cycle CDB bypass; {rdy, value}.
  function automatic logic [DATA_W:0] capture(input logic rdy, input logic [DATA_W-1:0] src,
                                              input logic cv, input logic [TAG_W-1:0] ct,
                                              input logic [DATA_W-1:0] cd);
    logic [DATA_W:0] r;
    if (rdy)                             r = {1'b1, src};
    else if (cv && src[TAG_W-1:0] == ct) r = {1'b1, cd};
    else                                 r = {1'b0, DATA_W'(src[TAG_W-1:0])};
    return r;
  endfunction

  assign iss_ready = (count_q != CNT_W'(DEPTH));
  assign iss_fire  = iss_valid && iss_ready && !flush;
  assign disp_fire = disp_valid && disp_ready && !flush;
  assign cap1      = capture(iss_s1_rdy, iss_s1, cdb_valid, cdb_tag, cdb_data);
  assign cap2      = capture(iss_s2_rdy, iss_s2, cdb_valid, cdb_tag, cdb_data);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = AGE_W'(i);
    end
  end

  rs_oldest_sel #(.DEPTH(DEPTH), .AGE_W(AGE_W)) u_sel (
    .cand_i      (valid_q & rdy1_q & rdy2_q),
    .age_i       (age_q),
    .grant_o     (grant),
    .any_valid_o (disp_valid)
  );

  always_comb begin
    disp_func = '0;
    disp_rob  = '0;
    disp_op1  = '0;
    disp_op2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        disp_func = func_q[i];
        disp_rob  = rob_q[i];
        disp_op1  = v1_q[i];
        disp_op2  = v2_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    age_d   = age_q;
    func_d  = func_q;
    rob_d   = rob_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!rdy1_q[i] && v1_q[i][TAG_W-1:0] == cdb_tag) begin
          rdy1_d[i] = 1'b1;
          v1_d[i]   = cdb_data;
        end
        if (!rdy2_q[i] && v2_q[i][TAG_W-1:0] == cdb_tag) begin
          rdy2_d[i] = 1'b1;
          v2_d[i]   = cdb_data;
        end
      end
      if (iss_fire && valid_q[i] && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
    end
    if (disp_fire) valid_d = valid_d & ~grant;
    // Issue targets a slot that is free this cycle, never the one being dispatched.
    if (iss_fire) begin
      valid_d[free_idx] = 1'b1;
      age_d[free_idx]   = '0;
      func_d[free_idx]  = iss_func;
      rob_d[free_idx]   = iss_rob;
      rdy1_d[free_idx]  = cap1[DATA_W];
      v1_d[free_idx]    = cap1[DATA_W-1:0];
      rdy2_d[free_idx]  = cap2[DATA_W];
      v2_d[free_idx]    = cap2[DATA_W-1:0];
    end
    if (flush) valid_d = '0;
  end

  always_comb begin
    count_d = count_q;
    if (flush)                       count_d = '0;
    else if (iss_fire && !disp_fire) count_d = count_q + 1'b1;
    else if (!iss_fire && disp_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      age_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

  // Payload fields are qualified by valid/rdy, so they carry no reset.
  always_ff @(posedge clk2) begin
    func_q <= func_d;
    rob_q  <= rob_d;
    v1_q   <= v1_d;
    v2_q   <= v2_d;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
endmodule
